// File: rtl/vending_txn_ctrl.sv
// Purpose: 20-cent vending transaction controller: coin credit, stock, dispense and change handshakes.
// Latency: coin accepted in cycle N shows in credit (and vend_req if price reached) in N+1; acks act next cycle.
// Backpressure: none; coins that cannot be taken are bounced via a one-cycle coin_reject pulse.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   coin[1:0]           01=5c, 10=10c, 00=idle, 11=invalid
//   cancel              level, refund current credit (COLLECT only)
//   restock             pulse, stock <= STOCK_INIT in any state
//   vend_ack, chg_ack   motor done / one nickel ejected pulses
//   vend_req, chg_req   handshake requests (decoded from state/credit)
//   coin_reject         registered one-cycle pulse
//   credit, stock       current credit in cents, items remaining
//   sold_out, busy      stock==0, state!=IDLE
// Optional: define VENDING_AUDIT_EN to add saturating sales_cnt / refund_cnt outputs.

module vending_txn_ctrl #(
    parameter int PRICE       = 20,
    parameter int CREDIT_MAX  = 35,
    parameter int STOCK_INIT  = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] coin,
    input  logic       cancel,
    input  logic       restock,
    input  logic       vend_ack,
    input  logic       chg_ack,
    output logic       vend_req,
    output logic       chg_req,
    output logic       coin_reject,
    output logic [5:0] credit,
    output logic [7:0] stock,
    output logic       sold_out,
    output logic       busy
`ifdef VENDING_AUDIT_EN
    ,
    output logic [15:0] sales_cnt,
    output logic [15:0] refund_cnt
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_VEND    = 2'd2;
    localparam logic [1:0] ST_CHANGE  = 2'd3;

    localparam int              TW        = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]   TIMER_END = TW'(TIMEOUT_CYC - 1);
    localparam logic [6:0]      PRICE_W   = 7'(PRICE);
    localparam logic [6:0]      CMAX_W    = 7'(CREDIT_MAX);

    logic [1:0]    state, state_nxt;
    logic [TW-1:0] timer;
    logic [6:0]    coin_val;
    logic [6:0]    credit_sum;
    logic          accept;
    logic          vend_done;
    logic          chg_take;
    logic [5:0]    credit_after_vend;
    logic [5:0]    credit_after_chg;
    logic          refund_entry;

    always_comb begin
        coin_val = 7'd0;
        case (coin)
            2'b01:   coin_val = 7'd5;
            2'b10:   coin_val = 7'd10;
            default: coin_val = 7'd0;
        endcase
    end

    assign credit_sum = {1'b0, credit} + coin_val;

    // Coin 11 has zero value, so it can never satisfy the acceptance test.
    assign accept = ((state == ST_IDLE) || (state == ST_COLLECT)) &&
                    (stock != 8'd0) && !cancel &&
                    (coin_val != 7'd0) && (credit_sum <= CMAX_W);

    assign vend_done         = (state == ST_VEND) && vend_ack;
    assign chg_take          = (state == ST_CHANGE) && chg_ack && (credit != 6'd0);
    assign credit_after_vend = credit - 6'(PRICE);
    assign credit_after_chg  = credit - 6'd5;

    always_comb begin
        state_nxt    = state;
        refund_entry = 1'b0;
        case (state)
            ST_IDLE: begin
                // With small prices a single coin could already reach the price.
                if (accept)
                    state_nxt = (credit_sum >= PRICE_W) ? ST_VEND : ST_COLLECT;
            end
            ST_COLLECT: begin
                if (cancel) begin
                    state_nxt    = ST_CHANGE;
                    refund_entry = 1'b1;
                end else if (accept) begin
                    if (credit_sum >= PRICE_W)
                        state_nxt = ST_VEND;
                end else if (timer == TIMER_END) begin
                    // An accepted coin restarts the idle window, so timeout only fires on a coinless cycle.
                    state_nxt    = ST_CHANGE;
                    refund_entry = 1'b1;
                end
            end
            ST_VEND: begin
                if (vend_ack)
                    state_nxt = (credit_after_vend != 6'd0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if (chg_take && (credit_after_chg == 6'd0))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            credit      <= 6'd0;
            timer       <= '0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nxt;
            coin_reject <= (coin != 2'b00) && !accept;

            if (accept)
                credit <= credit_sum[5:0];
            else if (vend_done)
                credit <= credit_after_vend;
            else if (chg_take)
                credit <= credit_after_chg;

            if ((state == ST_COLLECT) && (state_nxt == ST_COLLECT) && !accept)
                timer <= timer + 1'b1;
            else
                timer <= '0;
        end
    end

    // Restock takes priority over the sale decrement in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stock <= 8'(STOCK_INIT);
        else if (restock)
            stock <= 8'(STOCK_INIT);
        else if (vend_done)
            stock <= stock - 8'd1;
    end

    assign vend_req = (state == ST_VEND);
    assign chg_req  = (state == ST_CHANGE) && (credit != 6'd0);
    assign sold_out = (stock == 8'd0);
    assign busy     = (state != ST_IDLE);

`ifdef VENDING_AUDIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sales_cnt  <= 16'd0;
            refund_cnt <= 16'd0;
        end else begin
            if (vend_done && (sales_cnt != 16'hFFFF))
                sales_cnt <= sales_cnt + 16'd1;
            if (refund_entry && (refund_cnt != 16'hFFFF))
                refund_cnt <= refund_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vending_txn_ctrl.sv
// Purpose: self-checking bench for vending_txn_ctrl (directed scenarios + randomized run vs. reference model).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives acks directly.

module tb_vending_txn_ctrl;

    localparam int PRICE       = 20;
    localparam int CREDIT_MAX  = 35;
    localparam int STOCK_INIT  = 8;
    localparam int TIMEOUT_CYC = 50;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_VEND    = 2;
    localparam int M_CHANGE  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] coin;
    logic       cancel, restock, vend_ack, chg_ack;
    logic       vend_req, chg_req, coin_reject, sold_out, busy;
    logic [5:0] credit;
    logic [7:0] stock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transaction phase, credit in cents, items left, idle cycles, pending reject.
    int m_mode, m_credit, m_stock, m_idle;
    bit m_rej;

    vending_txn_ctrl #(
        .PRICE(PRICE), .CREDIT_MAX(CREDIT_MAX),
        .STOCK_INIT(STOCK_INIT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coin(coin), .cancel(cancel), .restock(restock),
        .vend_ack(vend_ack), .chg_ack(chg_ack), .vend_req(vend_req), .chg_req(chg_req),
        .coin_reject(coin_reject), .credit(credit), .stock(stock),
        .sold_out(sold_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = M_IDLE; m_credit = 0; m_stock = STOCK_INIT; m_idle = 0; m_rej = 0;
    endtask

    // Drive one cycle of inputs, advance the model by the transaction rules, sample 1 unit after the edge.
    task automatic step(input logic [1:0] c, input logic cn, input logic rs,
                        input logic va, input logic ca);
        int v;
        bit ok;
        coin = c; cancel = cn; restock = rs; vend_ack = va; chg_ack = ca;
        @(posedge clk);
        v  = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
        ok = (m_mode == M_IDLE || m_mode == M_COLLECT) && m_stock > 0 && !cn &&
             v > 0 && (m_credit + v) <= CREDIT_MAX;
        m_rej = (c != 2'b00) && !ok;
        case (m_mode)
            M_IDLE: if (ok) begin
                m_credit += v;
                m_mode = (m_credit >= PRICE) ? M_VEND : M_COLLECT;
            end
            M_COLLECT: begin
                if (cn) m_mode = M_CHANGE;
                else if (ok) begin
                    m_credit += v;
                    m_idle = 0;
                    if (m_credit >= PRICE) m_mode = M_VEND;
                end else if (m_idle == TIMEOUT_CYC - 1) m_mode = M_CHANGE;
                else m_idle++;
            end
            M_VEND: if (va) begin
                m_credit -= PRICE;
                m_stock  -= 1;
                m_mode = (m_credit > 0) ? M_CHANGE : M_IDLE;
            end
            default: if (ca && m_credit > 0) begin
                m_credit -= 5;
                if (m_credit == 0) m_mode = M_IDLE;
            end
        endcase
        if (rs) m_stock = STOCK_INIT;
        if (m_mode != M_COLLECT) m_idle = 0;
        #1;
        coin = 2'b00; cancel = 0; restock = 0; vend_ack = 0; chg_ack = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; coin = 0; cancel = 0; restock = 0; vend_ack = 0; chg_ack = 0;
        model_reset();
        #12;
        n_tests++;
        if ({vend_req, chg_req, coin_reject, busy, sold_out} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 00000", {vend_req, chg_req, coin_reject, busy, sold_out});
        end
        n_tests++;
        if (credit !== 6'd0 || stock !== 8'(STOCK_INIT)) begin
            n_fail++;
            $display("FAIL reset_regs credit=%0d stock=%0d exp 0/%0d", credit, stock, STOCK_INIT);
        end
        @(negedge clk) rst_n = 1;
    endtask

    task automatic test_exact_price();
        step(2'b10, 0, 0, 0, 0);
        step(2'b10, 0, 0, 0, 0);
        n_tests++;
        if (credit !== 6'd20 || vend_req !== 1'b1 || chg_req !== 1'b0) begin
            n_fail++;
            $display("FAIL exact_vend credit=%0d vend_req=%b chg_req=%b exp 20/1/0", credit, vend_req, chg_req);
        end
        step(2'b00, 0, 0, 1, 0);
        n_tests++;
        if (credit !== 6'd0 || stock !== 8'd7 || busy !== 1'b0 || chg_req !== 1'b0 || vend_req !== 1'b0) begin
            n_fail++;
            $display("FAIL exact_done credit=%0d stock=%0d busy=%b chg_req=%b vend_req=%b exp 0/7/0/0/0",
                     credit, stock, busy, chg_req, vend_req);
        end
    endtask

    task automatic test_overpay();
        step(2'b10, 0, 0, 0, 0);
        step(2'b01, 0, 0, 0, 0);
        step(2'b10, 0, 0, 0, 0);
        n_tests++;
        if (credit !== 6'd25 || vend_req !== 1'b1) begin
            n_fail++;
            $display("FAIL overpay_vend credit=%0d vend_req=%b exp 25/1", credit, vend_req);
        end
        step(2'b00, 0, 0, 1, 0);
        n_tests++;
        if (credit !== 6'd5 || chg_req !== 1'b1 || vend_req !== 1'b0) begin
            n_fail++;
            $display("FAIL overpay_change credit=%0d chg_req=%b vend_req=%b exp 5/1/0", credit, chg_req, vend_req);
        end
        step(2'b00, 0, 0, 0, 1);
        n_tests++;
        if (credit !== 6'd0 || chg_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overpay_idle credit=%0d chg_req=%b busy=%b exp 0/0/0", credit, chg_req, busy);
        end
    endtask

    task automatic test_cancel();
        int s0;
        s0 = m_stock;
        step(2'b01, 0, 0, 0, 0);
        step(2'b10, 1, 0, 0, 0);
        n_tests++;
        if (coin_reject !== 1'b1 || chg_req !== 1'b1 || credit !== 6'd5) begin
            n_fail++;
            $display("FAIL cancel_refund rej=%b chg_req=%b credit=%0d exp 1/1/5", coin_reject, chg_req, credit);
        end
        step(2'b00, 0, 0, 0, 1);
        n_tests++;
        if (busy !== 1'b0 || credit !== 6'd0 || stock !== 8'(s0) || coin_reject !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_idle busy=%b credit=%0d stock=%0d rej=%b exp 0/0/%0d/0",
                     busy, credit, stock, coin_reject, s0);
        end
    endtask

    task automatic test_reject();
        step(2'b11, 0, 0, 0, 0);
        n_tests++;
        if (coin_reject !== 1'b1 || credit !== 6'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_invalid rej=%b credit=%0d busy=%b exp 1/0/0", coin_reject, credit, busy);
        end
        step(2'b10, 0, 0, 0, 0);
        step(2'b10, 0, 0, 0, 0);
        step(2'b10, 0, 0, 0, 1);   // coin during VEND plus spurious chg_ack
        n_tests++;
        if (coin_reject !== 1'b1 || credit !== 6'd20 || vend_req !== 1'b1 || chg_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_in_vend rej=%b credit=%0d vend_req=%b chg_req=%b exp 1/20/1/0",
                     coin_reject, credit, vend_req, chg_req);
        end
        step(2'b00, 0, 0, 1, 0);
        n_tests++;
        if (coin_reject !== 1'b0 || busy !== 1'b0 || credit !== 6'd0) begin
            n_fail++;
            $display("FAIL reject_after rej=%b busy=%b credit=%0d exp 0/0/0", coin_reject, busy, credit);
        end
    endtask

    task automatic test_sold_out();
        for (int i = 0; i < 16 && m_stock > 0; i++) begin
            step(2'b10, 0, 0, 0, 0);
            step(2'b10, 0, 0, 0, 0);
            step(2'b00, 0, 0, 1, 0);
        end
        n_tests++;
        if (sold_out !== 1'b1 || stock !== 8'd0) begin
            n_fail++;
            $display("FAIL sold_out_flag sold_out=%b stock=%0d exp 1/0", sold_out, stock);
        end
        step(2'b01, 0, 0, 0, 0);
        n_tests++;
        if (coin_reject !== 1'b1 || credit !== 6'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sold_out_reject rej=%b credit=%0d busy=%b exp 1/0/0", coin_reject, credit, busy);
        end
        step(2'b00, 0, 1, 0, 0);
        n_tests++;
        if (stock !== 8'(STOCK_INIT) || sold_out !== 1'b0) begin
            n_fail++;
            $display("FAIL restock stock=%0d sold_out=%b exp %0d/0", stock, sold_out, STOCK_INIT);
        end
        step(2'b01, 0, 0, 0, 0);
        n_tests++;
        if (coin_reject !== 1'b0 || credit !== 6'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restock_accept rej=%b credit=%0d busy=%b exp 0/5/1", coin_reject, credit, busy);
        end
    endtask

    // Continues from the 5c left in COLLECT by the previous scenario.
    task automatic test_timeout();
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) step(2'b00, 0, 0, 0, 0);
        n_tests++;
        if (busy !== 1'b1 || chg_req !== 1'b0 || credit !== 6'd5) begin
            n_fail++;
            $display("FAIL timeout_early busy=%b chg_req=%b credit=%0d exp 1/0/5", busy, chg_req, credit);
        end
        step(2'b00, 0, 0, 0, 0);
        n_tests++;
        if (chg_req !== 1'b1 || credit !== 6'd5) begin
            n_fail++;
            $display("FAIL timeout_fire chg_req=%b credit=%0d exp 1/5", chg_req, credit);
        end
        step(2'b00, 0, 0, 0, 1);
        n_tests++;
        if (busy !== 1'b0 || credit !== 6'd0) begin
            n_fail++;
            $display("FAIL timeout_refund busy=%b credit=%0d exp 0/0", busy, credit);
        end
    endtask

    task automatic test_reset_mid();
        step(2'b10, 0, 0, 0, 0);
        step(2'b10, 0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        n_tests++;
        if (vend_req !== 1'b0 || credit !== 6'd0 || busy !== 1'b0 || chg_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid vend_req=%b credit=%0d busy=%b chg_req=%b exp 0/0/0/0",
                     vend_req, credit, busy, chg_req);
        end
        model_reset();
        @(negedge clk) rst_n = 1;
    endtask

    task automatic test_random();
        logic [1:0]  c;
        logic [18:0] got, exp;
        int r;
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            c = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            step(c, $urandom_range(0, 15) == 0, $urandom_range(0, 60) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            got = {vend_req, chg_req, coin_reject, credit, stock, sold_out, busy};
            exp = {m_mode == M_VEND, m_mode == M_CHANGE && m_credit > 0, m_rej,
                   6'(m_credit), 8'(m_stock), m_stock == 0, m_mode != M_IDLE};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cyc=%0d got vr/cr/rej/credit/stock/so/busy=%b/%b/%b/%0d/%0d/%b/%b exp %b/%b/%b/%0d/%0d/%b/%b",
                             i, got[18], got[17], got[16], got[15:10], got[9:2], got[1], got[0],
                             exp[18], exp[17], exp[16], exp[15:10], exp[9:2], exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_overpay();
        test_cancel();
        test_reject();
        test_sold_out();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
